id_dispatch_queue: RTL and testbench
====================================

Name: id_dispatch_queue

Overview:
- Instruction buffer between the fetch stage and the two decode slots.
- Accepts up to two fetched {pc, inst} packets per cycle and holds them in an in-order circular queue.
- Presents the two oldest packets to decode slot 0 and slot 1, and retires up to two per cycle under a per-slot valid/ready handshake.
- Also owns pipeline flush of the front end.

Parameters:
- DEPTH, 8, number of queue entries; power of two, >= 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all queued packets (branch mispredict / exception).
- in_valid  in  2  per-lane fetch packet valid; lane 0 is older.
- in_pc  in  2x32  fetch PC per lane.
- in_inst  in  2x32  fetch instruction word per lane.
- in_ready  out  1  queue can accept two packets this cycle.
- out_valid  out  2  slot packet valid; slot 0 is oldest.
- out_pc  out  2x32  PC presented to decode slot.
- out_inst  out  2x32  instruction presented to decode slot.
- out_ready  in  2  decode slot consumes the packet.
- count  out  CNT_W  current occupancy.

Behaviour:
- State: mem[DEPTH] of {pc, inst}; head, tail, count. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. mem is not reset.
- Reset: rst_n low at posedge gives head=tail=count=0. While rst_n is low, in_ready=0 and out_valid=0. After reset, in_ready=1.
- in_ready = !flush && (DEPTH - count >= 2). It depends on registered state only, never on out_ready.
- Enqueue, when in_ready:
  - Valid lanes are compacted in lane order: lane 0 writes mem[tail]; lane 1 writes mem[tail + in_valid[0]].
  - push = in_valid[0] + in_valid[1]; tail += push.
  - in_valid=2'b10 is legal and occupies one entry.
  - When in_ready=0, inputs are ignored; fetch must hold them.
- Outputs:
  - out_valid[0] = count >= 1; out_valid[1] = count >= 2. Both are forced to 0 during a flush cycle.
  - out_pc/out_inst[k] = mem[head+k] when out_valid[k], else 32'h0.
- Dequeue is strictly in order:
  - pop0 = out_valid[0] & out_ready[0]; pop1 = pop0 & out_valid[1] & out_ready[1].
  - out_ready[1] without out_ready[0] consumes nothing.
  - head += pop0 + pop1.
- Simultaneous push and pop: count_next = count + push - pop. Overflow is impossible because in_ready uses pre-pop count. Underflow is impossible by the out_valid gating.
- Latency: a packet written at edge N is visible on out_* in cycle N+1 (one-cycle minimum, without the bypass feature).
- Flush (synchronous; priority below reset, above all else): next state is head=tail=count=0. Same-cycle inputs are dropped and same-cycle pops are ignored. One cycle later in_ready=1.
- Wrap-around: head/tail roll from DEPTH-1 to 0 seamlessly. A two-lane write and a two-lane read may straddle the wrap.
- Full: count = DEPTH-1 or DEPTH gives in_ready=0, even if decode pops two that cycle.
- Empty: count=0 gives out_valid=0, outputs zero.

Optional Feature:
- Macro ID_QUEUE_BYPASS_EN. When defined, if count==0 and !flush, lane packets are forwarded combinationally to out_* in the same cycle:
  - out_valid = compacted in_valid.
  - Packets consumed via out_ready are not written; only unconsumed ones enqueue.
  - Zero-cycle latency when empty.
- When undefined, there is no combinational in->out path and latency is always >= 1.

Decomposition:
- Shared package id_pkg:
  - typedef inst_pkt_t {logic [31:0] pc; logic [31:0] inst;}
  - localparam ID_QUEUE_DEPTH = 8
  - localparam ISSUE_WIDTH = 2
- Natural sub-module: id_queue_mem, a DEPTH-entry array with two write ports at tail/tail+1 and two read ports at head/head+1, no reset. Pointer and count control stays in id_dispatch_queue.

Test Plan:
- Reset then fill: rst_n=0 for 2 cycles, then in_valid=2'b11 with pc 0x1c000000/0x1c000004 for 3 cycles, out_ready=0.
  - Expected: count 0->2->4->6, in_ready=1, out_pc[0]=0x1c000000, out_pc[1]=0x1c000004 from cycle after first write.
- Full: continue pushing at count=6.
  - Expected: count reaches 8, then in_ready=0 at count 8 and 7.
  - Apply out_ready=2'b11 with in_valid=2'b11 at count=8: count->6 and no write occurs.
- Partial pop: count=3, out_ready=2'b10.
  - Expected: no pop, count stays 3. Then out_ready=2'b01: count->2, out_pc[0] advances by one entry.
- Lane compaction and wrap: head=tail=7, in_valid=2'b10 with pc 0xA0, then 2'b11 with 0xB0/0xB4.
  - Expected: entries 7,0,1 hold 0xA0,0xB0,0xB4; out order 0xA0,0xB0,0xB4.
- Flush mid-traffic: count=5, flush=1 with in_valid=2'b11 and out_ready=2'b11.
  - Expected: next cycle count=0, out_valid=0, in_ready=1, and no flushed PC ever appears.
- Bypass (ID_QUEUE_BYPASS_EN): count=0, in_valid=2'b11 with pc 0x100/0x104, out_ready=2'b01.
  - Expected: out_pc[0]=0x100 the same cycle; next cycle count=1, out_pc[0]=0x104.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types and sizing for the instruction-decode dispatch queue.
package id_pkg;
  localparam int ID_QUEUE_DEPTH = 8;
  localparam int ISSUE_WIDTH    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_pkt_t;
endpackage

// File: rtl/id_queue_mem.sv
// Dispatch queue storage: two write ports at waddr/waddr+1, two read ports at raddr/raddr+1.
// Contents are deliberately not reset; validity is tracked by the controller.
module id_queue_mem
  import id_pkg::*;
#(
  parameter int DEPTH = ID_QUEUE_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic             we0_i,
  input  inst_pkt_t        wd0_i,
  input  logic             we1_i,
  input  inst_pkt_t        wd1_i,
  input  logic [PTR_W-1:0] raddr_i,
  output inst_pkt_t        rd0_o,
  output inst_pkt_t        rd1_o
);
  inst_pkt_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr_i] <= wd0_i;
    if (we1_i) mem_q[waddr_i + PTR_W'(1)] <= wd1_i;
  end

  assign rd0_o = mem_q[raddr_i];
  assign rd1_o = mem_q[raddr_i + PTR_W'(1)];
endmodule

// File: rtl/id_dispatch_queue.sv
// Fetch-to-decode in-order dispatch queue, two lanes in and two slots out, with front-end flush.
// Optional ID_QUEUE_BYPASS_EN forwards fetch packets straight to decode while the queue is empty.
module id_dispatch_queue
  import id_pkg::*;
#(
  parameter int DEPTH = ID_QUEUE_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [ISSUE_WIDTH-1:0]            in_valid,
  input  logic [ISSUE_WIDTH-1:0][31:0]      in_pc,
  input  logic [ISSUE_WIDTH-1:0][31:0]      in_inst,
  output logic                              in_ready,
  output logic [ISSUE_WIDTH-1:0]            out_valid,
  output logic [ISSUE_WIDTH-1:0][31:0]      out_pc,
  output logic [ISSUE_WIDTH-1:0][31:0]      out_inst,
  input  logic [ISSUE_WIDTH-1:0]            out_ready,
  output logic [CNT_W-1:0]                  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] push, pop, push_acc;
  logic             active, bypass, pop0, pop1, we0, we1;
  logic [1:0]       cvld, qvld;
  inst_pkt_t        lane0, lane1, cpkt0, cpkt1, rd0, rd1, slot0, slot1, wd0, wd1;

  assign active   = rst_n && !flush;
  // Uses pre-pop occupancy so decode never sits on the fetch ready path.
  assign in_ready = active && (count_q <= CNT_W'(DEPTH - 2));
  assign push     = CNT_W'(in_valid[0]) + CNT_W'(in_valid[1]);
  assign push_acc = in_ready ? push : '0;

  assign lane0 = '{pc: in_pc[0], inst: in_inst[0]};
  assign lane1 = '{pc: in_pc[1], inst: in_inst[1]};
  assign cpkt0 = in_valid[0] ? lane0 : lane1;
  assign cpkt1 = lane1;
  assign cvld  = {&in_valid, |in_valid};
  assign qvld  = {count_q >= CNT_W'(2), count_q != '0};

`ifdef ID_QUEUE_BYPASS_EN
  assign bypass = active && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = 2'b00;
    if (bypass)      out_valid = cvld;
    else if (active) out_valid = qvld;
    slot0 = bypass ? cpkt0 : rd0;
    slot1 = bypass ? cpkt1 : rd1;
    out_pc[0]   = out_valid[0] ? slot0.pc   : 32'h0;
    out_inst[0] = out_valid[0] ? slot0.inst : 32'h0;
    out_pc[1]   = out_valid[1] ? slot1.pc   : 32'h0;
    out_inst[1] = out_valid[1] ? slot1.inst : 32'h0;
  end

  assign pop0 = out_valid[0] & out_ready[0];
  assign pop1 = pop0 & out_valid[1] & out_ready[1];
  assign pop  = CNT_W'(pop0) + CNT_W'(pop1);

  always_comb begin
    wd0    = cpkt0;
    wd1    = cpkt1;
    we0    = in_ready & cvld[0];
    we1    = in_ready & cvld[1];
    tail_d = tail_q + PTR_W'(push_acc);
    head_d = head_q + PTR_W'(pop);
`ifdef ID_QUEUE_BYPASS_EN
    // Forwarded packets that decode took this cycle never touch storage.
    if (bypass) begin
      wd0    = pop0 ? cpkt1 : cpkt0;
      we0    = pop0 ? (cvld[1] & ~pop1) : cvld[0];
      we1    = ~pop0 & cvld[1];
      tail_d = tail_q + PTR_W'(push - pop);
      head_d = head_q;
    end
`endif
    count_d = count_q + push_acc - pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  id_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk     (clk),
    .waddr_i (tail_q),
    .we0_i   (we0),
    .wd0_i   (wd0),
    .we1_i   (we1),
    .wd1_i   (wd1),
    .raddr_i (head_q),
    .rd0_o   (rd0),
    .rd1_o   (rd1)
  );
endmodule

// File: tb/tb_id_dispatch_queue.sv
// Directed bench for id_dispatch_queue with an in-order scoreboard of expected decode packets.
module tb_id_dispatch_queue;
  import id_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [1:0]             in_valid;
  logic [1:0][31:0]       in_pc;
  logic [1:0][31:0]       in_inst;
  logic                   in_ready;
  logic [1:0]             out_valid;
  logic [1:0][31:0]       out_pc;
  logic [1:0][31:0]       out_inst;
  logic [1:0]             out_ready;
  logic [CNT_W-1:0]       count;

  int errors = 0;
  int checks = 0;
  inst_pkt_t sbq[$];

  id_dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, compare against the scoreboard view, update model, advance clock.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] r, input logic f);
    inst_pkt_t view[$];
    inst_pkt_t nin[$];
    logic exp_rdy, byp, m_pop0, m_pop1;
    logic [1:0] ov;
    in_valid   = v;
    in_pc[0]   = p0;
    in_pc[1]   = p1;
    in_inst[0] = mk_inst(p0);
    in_inst[1] = mk_inst(p1);
    out_ready  = r;
    flush      = f;
    if (v[0]) nin.push_back('{pc: p0, inst: mk_inst(p0)});
    if (v[1]) nin.push_back('{pc: p1, inst: mk_inst(p1)});
    exp_rdy = !f && (sbq.size() <= DEPTH - 2);
    byp = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
    byp = !f && (sbq.size() == 0);
`endif
    view = sbq;
    if (byp) view = nin;
    if (f) view.delete();
    ov[0] = view.size() >= 1;
    ov[1] = view.size() >= 2;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("count", 32'(count), 32'(sbq.size()));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("out_pc0", out_pc[0], ov[0] ? view[0].pc : 32'h0);
    chk("out_inst0", out_inst[0], ov[0] ? view[0].inst : 32'h0);
    chk("out_pc1", out_pc[1], ov[1] ? view[1].pc : 32'h0);
    chk("out_inst1", out_inst[1], ov[1] ? view[1].inst : 32'h0);
    m_pop0 = ov[0] & r[0];
    m_pop1 = m_pop0 & ov[1] & r[1];
    if (f) begin
      sbq.delete();
    end else begin
      if (byp) sbq = nin;
      else if (exp_rdy) foreach (nin[i]) sbq.push_back(nin[i]);
      if (m_pop0) void'(sbq.pop_front());
      if (m_pop1) void'(sbq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 2'b11; out_ready = 2'b11;
    in_pc = '0; in_inst = '0;
    // Reset: inputs held active must be ignored.
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid2", 32'(out_valid), 32'h0);
    rst_n = 1'b1; in_valid = 2'b00; out_ready = 2'b00;

    // Fill
    step(2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'b00, 1'b0);
    step(2'b11, 32'h1c00_0008, 32'h1c00_000c, 2'b00, 1'b0);
    step(2'b11, 32'h1c00_0010, 32'h1c00_0014, 2'b00, 1'b0);
    chk("fill_count", 32'(count), 32'd6);
    chk("fill_pc0", out_pc[0], 32'h1c00_0000);
    chk("fill_pc1", out_pc[1], 32'h1c00_0004);

    // Full handling
    step(2'b11, 32'h1c00_0018, 32'h1c00_001c, 2'b00, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    step(2'b11, 32'h2000_0000, 32'h2000_0004, 2'b11, 1'b0);
    chk("full_pop2_count", 32'(count), 32'd6);
    step(2'b11, 32'h2000_0008, 32'h2000_000c, 2'b00, 1'b0);
    step(2'b11, 32'h2000_0010, 32'h2000_0014, 2'b01, 1'b0);
    chk("cnt7_count", 32'(count), 32'd7);
    step(2'b11, 32'h2000_0018, 32'h2000_001c, 2'b00, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

    // Partial pop at count 3
    chk("pp_count", 32'(count), 32'd3);
    step(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);
    chk("pp_nopop", 32'(count), 32'd3);
    step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    chk("pp_pop1", 32'(count), 32'd2);
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

    // Walk pointers to head=tail=7, then compaction across the wrap
    step(2'b11, 32'h40, 32'h44, 2'b00, 1'b0);
    step(2'b11, 32'h48, 32'h4c, 2'b11, 1'b0);
    step(2'b01, 32'h50, 32'h0, 2'b11, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    chk("wrap_empty", 32'(count), 32'd0);
    step(2'b10, 32'h0, 32'hA0, 2'b00, 1'b0);
    step(2'b11, 32'hB0, 32'hB4, 2'b00, 1'b0);
    chk("wrap_pc0", out_pc[0], 32'hA0);
    chk("wrap_pc1", out_pc[1], 32'hB0);
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    chk("wrap_pc_after", out_pc[0], 32'hB4);

    // Flush mid-traffic at count 5
    step(2'b11, 32'hC0, 32'hC4, 2'b00, 1'b0);
    step(2'b11, 32'hC8, 32'hCC, 2'b00, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd5);
    step(2'b11, 32'hD0, 32'hD4, 2'b11, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    step(2'b11, 32'hE0, 32'hE4, 2'b00, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

    // Empty-queue arrival with decode taking slot 0
    step(2'b11, 32'h100, 32'h104, 2'b01, 1'b0);
    in_valid = 2'b00; out_ready = 2'b00; #1;
`ifdef ID_QUEUE_BYPASS_EN
    chk("byp_count", 32'(count), 32'd1);
    chk("byp_pc0", out_pc[0], 32'h104);
`else
    chk("nobyp_count", 32'(count), 32'd2);
    chk("nobyp_pc0", out_pc[0], 32'h100);
`endif
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
